// File: rtl/wb_inst_feeder.sv
// Wishbone slave that feeds queued 32-bit instructions to a 128-bit core port.
// Reads return the FIFO head in the addressed lane. Writes are captured for observation.
module wb_inst_feeder #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] FILL_WORD   = 32'hF0081003,
  parameter int unsigned ACK_LATENCY = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_inst_valid,
  input  logic [31:0]                   i_inst,
  output logic                          o_inst_ready,
  input  logic                          i_wb_cyc,
  input  logic                          i_wb_stb,
  input  logic                          i_wb_we,
  input  logic [31:0]                   i_wb_adr,
  input  logic [15:0]                   i_wb_sel,
  input  logic [127:0]                  i_wb_dat,
  output logic [127:0]                  o_wb_dat,
  output logic                          o_wb_ack,
  output logic                          o_wb_err,
  output logic                          o_st_valid,
  output logic [31:0]                   o_st_adr,
  output logic [127:0]                  o_st_dat,
  output logic [15:0]                   o_st_sel,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic [15:0]                   o_starve_cnt
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0]  WAIT_LOAD = 3'((ACK_LATENCY > 0) ? ACK_LATENCY - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [2:0]     r_wait_cnt;

  logic           r_req_we;
  logic [31:0]    r_req_adr;
  logic [15:0]    r_req_sel;
  logic [127:0]   r_req_dat;

  logic [31:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;

  logic [31:0]    r_st_adr;
  logic [127:0]   r_st_dat;
  logic [15:0]    r_st_sel;
  logic [15:0]    r_starve_cnt;

  logic           w_latch;
  logic           w_push;
  logic           w_pop;
  logic           w_starve;
  logic           w_st_fire;
  logic [31:0]    w_head;

  assign o_inst_ready = (r_count < DEPTH_CNT);
  assign w_push       = i_inst_valid && o_inst_ready;
  assign w_head       = r_mem[r_rd_ptr];
  assign o_fifo_count = r_count;
  assign o_starve_cnt = r_starve_cnt;

  // Captured-write outputs show the latched request during the pulse and hold it afterwards
  assign o_st_valid = w_st_fire;
  assign o_st_adr   = w_st_fire ? r_req_adr : r_st_adr;
  assign o_st_dat   = w_st_fire ? r_req_dat : r_st_dat;
  assign o_st_sel   = w_st_fire ? r_req_sel : r_st_sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_pop        = 1'b0;
    w_starve     = 1'b0;
    w_st_fire    = 1'b0;
    o_wb_ack     = 1'b0;
    o_wb_err     = 1'b0;
    o_wb_dat     = {4{FILL_WORD}};
    case (r_state)
      S_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          w_latch      = 1'b1;
          w_state_next = (ACK_LATENCY > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (!i_wb_cyc) begin
          w_state_next = S_IDLE;
        end else if (r_wait_cnt == 3'd0) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
        if (!r_req_we) begin
          o_wb_ack = 1'b1;
          if (r_count != '0) begin
            w_pop = 1'b1;
            for (int unsigned l = 0; l < 4; l++) begin
              if (r_req_adr[3:2] == l[1:0]) begin
                o_wb_dat[l*32 +: 32] = w_head;
              end
            end
          end else begin
            w_starve = 1'b1;
          end
        end else if (r_req_sel != '0) begin
          o_wb_ack  = 1'b1;
          w_st_fire = 1'b1;
        end else begin
          o_wb_err = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
      r_req_we   <= 1'b0;
      r_req_adr  <= '0;
      r_req_sel  <= '0;
      r_req_dat  <= '0;
    end else if (w_latch) begin
      r_wait_cnt <= WAIT_LOAD;
      r_req_we   <= i_wb_we;
      r_req_adr  <= i_wb_adr;
      r_req_sel  <= i_wb_sel;
      r_req_dat  <= i_wb_dat;
    end else if (r_state == S_WAIT && r_wait_cnt != 3'd0) begin
      r_wait_cnt <= r_wait_cnt - 3'd1;
    end
  end

  // Storage is not reset; pointers and count define which entries are live
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_inst;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st_adr     <= '0;
      r_st_dat     <= '0;
      r_st_sel     <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (w_st_fire) begin
        r_st_adr <= r_req_adr;
        r_st_dat <= r_req_dat;
        r_st_sel <= r_req_sel;
      end
      if (w_starve && r_starve_cnt != 16'hFFFF) begin
        r_starve_cnt <= r_starve_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_inst_feeder.sv
// Scoreboard bench for wb_inst_feeder: directed transfers queue expected responses,
// a negedge monitor pops and compares whenever the DUT acks or errors.
module tb_wb_inst_feeder;

  localparam logic [31:0] FILL = 32'hF0081003;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         inst_valid = 1'b0;
  logic [31:0]  inst = '0;
  logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic         cyc3 = 1'b0, stb3 = 1'b0;
  logic [31:0]  adr = '0;
  logic [15:0]  sel = '0;
  logic [127:0] wdat = '0;

  logic         ready, ack, err, st_valid;
  logic [127:0] wb_dat, st_dat;
  logic [31:0]  st_adr;
  logic [15:0]  st_sel, starve;
  logic [3:0]   count;

  logic         ready3, ack3, err3, st_valid3;
  logic [127:0] wb_dat3, st_dat3;
  logic [31:0]  st_adr3;
  logic [15:0]  st_sel3, starve3;
  logic [3:0]   count3;

  wb_inst_feeder #(.FIFO_DEPTH(8), .FILL_WORD(FILL), .ACK_LATENCY(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_inst_valid(inst_valid), .i_inst(inst),
    .o_inst_ready(ready), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_dat(wdat), .o_wb_dat(wb_dat),
    .o_wb_ack(ack), .o_wb_err(err), .o_st_valid(st_valid), .o_st_adr(st_adr),
    .o_st_dat(st_dat), .o_st_sel(st_sel), .o_fifo_count(count), .o_starve_cnt(starve)
  );

  wb_inst_feeder #(.FIFO_DEPTH(8), .FILL_WORD(FILL), .ACK_LATENCY(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_inst_valid(inst_valid), .i_inst(inst),
    .o_inst_ready(ready3), .i_wb_cyc(cyc3), .i_wb_stb(stb3), .i_wb_we(we),
    .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_dat(wdat), .o_wb_dat(wb_dat3),
    .o_wb_ack(ack3), .o_wb_err(err3), .o_st_valid(st_valid3), .o_st_adr(st_adr3),
    .o_st_dat(st_dat3), .o_st_sel(st_sel3), .o_fifo_count(count3), .o_starve_cnt(starve3)
  );

  typedef struct {
    logic         ack;
    logic         err;
    logic [127:0] dat;
    logic         stv;
    logic [31:0]  sadr;
    logic [127:0] sdat;
    logic [15:0]  ssel;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  function automatic logic [127:0] lane_put(input logic [31:0] w, input int unsigned l);
    logic [127:0] r;
    r = {4{FILL}};
    r[l*32 +: 32] = w;
    return r;
  endfunction

  // Monitor: every response on the L=1 instance must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (ack || err || st_valid)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual ack=%b err=%b stv=%b expected none", ack, err, st_valid);
      end else begin
        e = sb.pop_front();
        chk("resp_ack", ack, e.ack);
        chk("resp_err", err, e.err);
        chk("resp_dat", wb_dat, e.dat);
        chk("resp_st_valid", st_valid, e.stv);
        if (e.stv) begin
          chk("resp_st_adr", st_adr, e.sadr);
          chk("resp_st_dat", st_dat, e.sdat);
          chk("resp_st_sel", st_sel, e.ssel);
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    @(posedge clk); #1;
    inst_valid = 1'b1;
    inst = w;
    @(posedge clk); #1;
    inst_valid = 1'b0;
  endtask

  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [15:0] s,
                          input logic [127:0] d, input int exp_lat);
    int start;
    bit got;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    start = cyc_n;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (ack || err) got = 1'b1;
    end
    chk("xfer_completed", got, 1'b1);
    if (got) chk("xfer_latency", cyc_n - start, exp_lat);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [127:0] expd);
    exp_t e;
    e = '{ack: 1'b1, err: 1'b0, dat: expd, stv: 1'b0, sadr: '0, sdat: '0, ssel: '0};
    sb.push_back(e);
    bus_xfer(1'b0, a, 16'hFFFF, '0, 2);
  endtask

  initial begin
    exp_t e;
    int start;
    bit got;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_count", count, 4'd0);
    chk("rst_ack", ack, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_st_valid", st_valid, 1'b0);
    chk("rst_wb_dat", wb_dat, {4{FILL}});
    chk("rst_st_adr", st_adr, 32'd0);
    chk("rst_st_dat", st_dat, 128'd0);
    chk("rst_st_sel", st_sel, 16'd0);
    chk("rst_starve", starve, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Two pushes, two lane-addressed reads
    push_word(32'h11111111);
    push_word(32'h22222222);
    @(negedge clk);
    chk("count_after_2_push", count, 4'd2);
    rd(32'h0, {FILL, FILL, FILL, 32'h11111111});
    rd(32'h4, {FILL, FILL, 32'h22222222, FILL});
    @(negedge clk);
    chk("count_after_2_pop", count, 4'd0);

    // Fill to full, then a push offered alongside a pop must be refused
    for (int i = 0; i < 8; i++) push_word(32'hA0000000 + i);
    @(negedge clk);
    chk("full_count", count, 4'd8);
    chk("full_ready", ready, 1'b0);
    @(posedge clk); #1;
    inst_valid = 1'b1;
    inst = 32'hDEADDEAD;
    rd(32'h8, lane_put(32'hA0000000, 2));
    inst_valid = 1'b0;
    @(negedge clk);
    chk("pop_full_count", count, 4'd7);
    chk("pop_full_ready", ready, 1'b1);
    for (int i = 1; i < 8; i++) rd((i % 4) * 4, lane_put(32'hA0000000 + i, i % 4));
    @(negedge clk);
    chk("drained_count", count, 4'd0);

    // Starved read
    rd(32'hC, {4{FILL}});
    @(negedge clk);
    chk("starve_cnt", starve, 16'd1);
    chk("starve_count", count, 4'd0);

    // Captured write, then a zero-select write that must error
    e = '{ack: 1'b1, err: 1'b0, dat: {4{FILL}}, stv: 1'b1,
          sadr: 32'h100, sdat: 128'hA5, ssel: 16'h000F};
    sb.push_back(e);
    bus_xfer(1'b1, 32'h100, 16'h000F, 128'hA5, 2);
    e = '{ack: 1'b0, err: 1'b1, dat: {4{FILL}}, stv: 1'b0, sadr: '0, sdat: '0, ssel: '0};
    sb.push_back(e);
    bus_xfer(1'b1, 32'h200, 16'h0000, 128'h5A, 2);
    @(negedge clk);
    chk("st_adr_held", st_adr, 32'h100);
    chk("st_sel_held", st_sel, 16'h000F);
    chk("write_no_fifo", count, 4'd0);

    // Reset asserted while a read waits, with three entries queued
    push_word(32'h33333333);
    push_word(32'h44444444);
    push_word(32'h55555555);
    @(negedge clk);
    chk("pre_reset_count", count, 4'd3);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 16'hFFFF;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_count", count, 4'd0);
    chk("midrst_ready", ready, 1'b1);
    chk("midrst_ack", ack, 1'b0);
    chk("midrst_wb_dat", wb_dat, {4{FILL}});
    chk("midrst_starve", starve, 16'd0);
    chk("midrst_st_adr", st_adr, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("post_rst_count", count, 4'd0);

    // ACK_LATENCY=3 instance: abort during WAIT, then a full-latency read
    push_word(32'hCAFE0001);
    @(negedge clk);
    chk("l3_count_push", count3, 4'd1);
    @(posedge clk); #1;
    cyc3 = 1'b1; stb3 = 1'b1; we = 1'b0; adr = 32'h0; sel = 16'hFFFF;
    @(posedge clk);
    @(posedge clk); #1;
    cyc3 = 1'b0; stb3 = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ack3 || err3) got = 1'b1;
    end
    chk("l3_abort_no_ack", got, 1'b0);
    chk("l3_abort_no_pop", count3, 4'd1);
    @(posedge clk); #1;
    cyc3 = 1'b1; stb3 = 1'b1;
    start = cyc_n;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (ack3 || err3) got = 1'b1;
    end
    chk("l3_read_completed", got, 1'b1);
    if (got) begin
      chk("l3_latency", cyc_n - start, 4);
      chk("l3_ack", ack3, 1'b1);
      chk("l3_dat", wb_dat3, {FILL, FILL, FILL, 32'hCAFE0001});
    end
    @(posedge clk); #1;
    cyc3 = 1'b0; stb3 = 1'b0;
    @(negedge clk);
    chk("l3_count_pop", count3, 4'd0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
